// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler: derives the physics tick (game_tick[1], once per frame)
// and the decision/animation tick (game_tick[0], every `period` frames) from
// the video frame pulse. The game_tick[0] period shrinks with speed_level,
// which climbs every LEVEL_UP_TICKS decision ticks spent in RUN.
module game_tick_scheduler #(
  parameter int unsigned BASE_PERIOD    = 6,
  parameter int unsigned MIN_PERIOD     = 2,
  parameter int unsigned LEVEL_UP_TICKS = 64,
  parameter int unsigned MAX_LEVEL      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_pulse,
  input  logic       game_start_pulse,
  input  logic       game_over_pulse,
  output logic [1:0] game_tick,
  output logic [2:0] speed_level,
  output logic       running
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FROZEN
  } state_t;

  localparam logic [3:0] BASE_P     = 4'(BASE_PERIOD);
  localparam logic [3:0] MIN_P      = 4'(MIN_PERIOD);
  localparam logic [3:0] SHRINK_MAX = 4'(BASE_PERIOD - MIN_PERIOD);
  localparam logic [7:0] LVL_LAST   = 8'(LEVEL_UP_TICKS - 1);
  localparam logic [2:0] LVL_MAX    = 3'(MAX_LEVEL);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] frame_cnt;
  logic [3:0] frame_cnt_nxt;
  logic [7:0] lvl_cnt;
  logic [7:0] lvl_cnt_nxt;
  logic [2:0] speed_nxt;
  logic [3:0] period;
  logic [3:0] period_m1;
  logic       tick0;
  logic       tick1;

  // Current decision-tick period; the clamp is decided before subtracting so
  // the 4-bit difference can never wrap below MIN_PERIOD.
  always_comb begin
    period = BASE_P;
    if (state == ST_RUN) begin
      if ({1'b0, speed_level} >= SHRINK_MAX) period = MIN_P;
      else                                    period = BASE_P - {1'b0, speed_level};
    end
    period_m1 = period - 4'd1;
  end

  // Next-state, counter and tick decode; ticks use the pre-transition state.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    lvl_cnt_nxt   = lvl_cnt;
    speed_nxt     = speed_level;

    // The >= compare fires straight away if a level-up shrank the period
    // below the count already reached.
    tick0 = frame_pulse && (frame_cnt >= period_m1);
    tick1 = frame_pulse && (state != ST_FROZEN);

    if (frame_pulse) frame_cnt_nxt = tick0 ? 4'd0 : frame_cnt + 4'd1;

    if (tick0 && (state == ST_RUN)) begin
      if (lvl_cnt == LVL_LAST) begin
        lvl_cnt_nxt = 8'd0;
        if (speed_level < LVL_MAX) speed_nxt = speed_level + 3'd1;
      end else begin
        lvl_cnt_nxt = lvl_cnt + 8'd1;
      end
    end

    unique case (state)
      ST_IDLE, ST_FROZEN: begin
        // A crash event in the same cycle cancels the start.
        if (game_start_pulse && !game_over_pulse) begin
          state_nxt     = ST_RUN;
          frame_cnt_nxt = 4'd0;
          lvl_cnt_nxt   = 8'd0;
          speed_nxt     = 3'd0;
        end
      end
      ST_RUN: begin
        if (game_over_pulse) state_nxt = ST_FROZEN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, regardless of statement order.
    if (!rst_n) begin
      state       <= ST_IDLE;
      frame_cnt   <= 4'd0;
      lvl_cnt     <= 8'd0;
      speed_level <= 3'd0;
      running     <= 1'b0;
      game_tick   <= 2'b00;
    end else begin
      state       <= state_nxt;
      frame_cnt   <= frame_cnt_nxt;
      lvl_cnt     <= lvl_cnt_nxt;
      speed_level <= speed_nxt;
      running     <= (state_nxt == ST_RUN);
      game_tick   <= {tick1, tick0};
    end
  end

endmodule
